// File: rtl/int_to_half.sv
// Converts a 16-bit integer (unsigned or two's-complement) to IEEE754 binary16.
// Normalises one bit per cycle, then rounds to nearest-even in a single ROUND cycle.
module int_to_half #(
    parameter int SIGNED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dataIn,
    input  logic        R_I,
    output logic [15:0] dataOut,
    output logic        R_O,
    output logic        ERROR
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_sign;
    logic        w_signNext;
    logic [15:0] r_mag;
    logic [15:0] w_magNext;
    logic [4:0]  r_exp;
    logic [4:0]  w_expNext;
    logic        r_zeroPend;
    logic        w_zeroPendNext;
    logic [15:0] r_dataOut;
    logic [15:0] w_dataOutNext;
    logic        r_ready;
    logic        w_readyNext;
    logic        r_error;
    logic        w_errorNext;

    logic        w_inSign;
    logic [15:0] w_inMag;
    logic [9:0]  w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_roundUp;
    logic [10:0] w_mantSum;
    logic [4:0]  w_expRound;
    logic        w_overflow;

    assign w_inSign = (SIGNED != 0) ? dataIn[15] : 1'b0;
    assign w_inMag  = w_inSign ? (~dataIn + 16'd1) : dataIn;

    // Once normalised, mag[15] is the hidden bit and mag[4:0] are the discarded bits.
    assign w_mant     = r_mag[14:5];
    assign w_guard    = r_mag[4];
    assign w_sticky   = |r_mag[3:0];
    assign w_roundUp  = w_guard & (w_sticky | w_mant[0]);
    assign w_mantSum  = {1'b0, w_mant} + {10'd0, w_roundUp};
    assign w_expRound = r_exp + {4'd0, w_mantSum[10]};
    assign w_overflow = (w_expRound == 5'd31);

    always_comb begin
        w_stateNext    = r_state;
        w_signNext     = r_sign;
        w_magNext      = r_mag;
        w_expNext      = r_exp;
        w_zeroPendNext = 1'b0;
        w_dataOutNext  = r_dataOut;
        w_readyNext    = r_zeroPend;
        w_errorNext    = 1'b0;

        // A zero operand never enters NORM; its result is published one edge later.
        if (r_zeroPend) begin
            w_dataOutNext = 16'h0000;
        end

        case (r_state)
            IDLE: begin
                if (R_I) begin
                    if (w_inMag == 16'd0) begin
                        w_zeroPendNext = 1'b1;
                    end else begin
                        w_signNext  = w_inSign;
                        w_magNext   = w_inMag;
                        w_expNext   = 5'd30;
                        w_stateNext = NORM;
                    end
                end
            end
            NORM: begin
                if (r_mag[15]) begin
                    w_stateNext = ROUND;
                end else begin
                    w_magNext = {r_mag[14:0], 1'b0};
                    w_expNext = r_exp - 5'd1;
                end
            end
            ROUND: begin
                w_readyNext = 1'b1;
                w_errorNext = w_overflow;
                if (w_overflow) begin
                    w_dataOutNext = {r_sign, 5'b11111, 10'd0};
                end else begin
                    w_dataOutNext = {r_sign, w_expRound, w_mantSum[9:0]};
                end
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_mag      <= 16'd0;
            r_exp      <= 5'd0;
            r_zeroPend <= 1'b0;
            r_dataOut  <= 16'h0000;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_sign     <= w_signNext;
            r_mag      <= w_magNext;
            r_exp      <= w_expNext;
            r_zeroPend <= w_zeroPendNext;
            r_dataOut  <= w_dataOutNext;
            r_ready    <= w_readyNext;
            r_error    <= w_errorNext;
        end
    end

    assign dataOut = r_dataOut;
    assign R_O     = r_ready;
    assign ERROR   = r_error;

endmodule

// File: tb/tb_int_to_half.sv
// Bench for int_to_half: an unsigned and a signed instance run side by side against
// an arithmetic reference model, plus literal results/latencies for known operands.
module tb_int_to_half;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dinA[2];
    logic        riA[2];
    logic [15:0] doutA[2];
    logic        roA[2];
    logic        errA[2];

    always #5 clk = ~clk;

    int_to_half #(.SIGNED(0)) dut0 (
        .clk(clk), .reset(reset), .dataIn(dinA[0]), .R_I(riA[0]),
        .dataOut(doutA[0]), .R_O(roA[0]), .ERROR(errA[0])
    );

    int_to_half #(.SIGNED(1)) dut1 (
        .clk(clk), .reset(reset), .dataIn(dinA[1]), .R_I(riA[1]),
        .dataOut(doutA[1]), .R_O(roA[1]), .ERROR(errA[1])
    );

    int          cyc;
    bit          checkEn;
    int          nCompared;
    int          nMismatched;

    bit          mBusy[2];
    int          mDue[2];
    logic [15:0] mPendData[2];
    logic        mPendErr[2];
    bit          mZero[2];
    logic [15:0] expData[2];
    logic        expRdy[2];
    logic        expErr[2];

    int          litSeq[2];
    int          litDone[2];
    logic [15:0] litData[2];
    logic        litErr[2];
    int          litLat[2];
    int          litArmCyc[2];

    // Reference conversion in plain integer arithmetic: locate the top set bit, scale
    // to an 11-bit significand and round half-to-even on the remainder.
    function automatic void refConv(input logic [15:0] d, input bit sgn,
                                    output logic [15:0] res, output logic err, output int lat);
        int m, p, e, q, sh, rem, half;
        bit s;
        s   = sgn && d[15];
        m   = s ? (65536 - int'(d)) : int'(d);
        res = 16'h0000;
        err = 1'b0;
        lat = 1;
        if (m == 0) return;
        p = 15;
        while (((m >> p) & 1) == 0) p--;
        e = 15 + p;
        if (p <= 10) begin
            q = m << (10 - p);
        end else begin
            sh   = p - 10;
            q    = m >> sh;
            rem  = m & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end
        lat = (15 - p) + 2;
        if (e >= 31) begin
            res = {s, 5'b11111, 10'd0};
            err = 1'b1;
        end else begin
            res = {s, 5'(e), 10'(q - 1024)};
        end
    endfunction

    function automatic logic [15:0] randData();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: randData = r;
            1: randData = r & 16'h00FF;
            2: randData = 16'hFFE0 | (r & 16'h001F);
            3: randData = 16'h0000;
            default: randData = 16'h8000 | (r & 16'h000F);
        endcase
    endfunction

    // Cycle model: one outstanding conversion per instance, result due a fixed
    // number of edges after acceptance; zero operands report on the next edge.
    initial begin
        logic [15:0] rd;
        logic        re;
        int          rl;
        cyc     = 0;
        checkEn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mBusy[i] = 1'b0; mZero[i] = 1'b0; mDue[i] = 0;
            mPendData[i] = 16'h0; mPendErr[i] = 1'b0;
            expData[i] = 16'h0; expRdy[i] = 1'b0; expErr[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                expRdy[i] = 1'b0;
                expErr[i] = 1'b0;
                if (reset) begin
                    mBusy[i]   = 1'b0;
                    mZero[i]   = 1'b0;
                    expData[i] = 16'h0000;
                end else begin
                    if (mZero[i]) begin
                        expRdy[i]  = 1'b1;
                        expData[i] = 16'h0000;
                        mZero[i]   = 1'b0;
                    end
                    if (mBusy[i]) begin
                        if (cyc == mDue[i]) begin
                            expRdy[i]  = 1'b1;
                            expData[i] = mPendData[i];
                            expErr[i]  = mPendErr[i];
                            mBusy[i]   = 1'b0;
                        end
                    end else if (riA[i]) begin
                        refConv(dinA[i], (i == 1), rd, re, rl);
                        if (rl == 1) begin
                            mZero[i] = 1'b1;
                        end else begin
                            mBusy[i]     = 1'b1;
                            mDue[i]      = cyc + rl;
                            mPendData[i] = rd;
                            mPendErr[i]  = re;
                        end
                    end
                end
            end
            checkEn = 1'b1;
        end
    end

    task automatic checkOutput(input int i);
        int lat;
        nCompared++;
        if (roA[i] !== expRdy[i]) begin
            nMismatched++;
            $display("[TB] FAIL R_O inst%0d cyc%0d: got %b, want %b", i, cyc, roA[i], expRdy[i]);
        end
        nCompared++;
        if (errA[i] !== expErr[i]) begin
            nMismatched++;
            $display("[TB] FAIL ERROR inst%0d cyc%0d: got %b, want %b", i, cyc, errA[i], expErr[i]);
        end
        nCompared++;
        if (doutA[i] !== expData[i]) begin
            nMismatched++;
            $display("[TB] FAIL dataOut inst%0d cyc%0d: got %h, want %h", i, cyc, doutA[i], expData[i]);
        end
        if (roA[i] === 1'b1 && litSeq[i] != litDone[i] && (cyc - litArmCyc[i] - 1) >= 1) begin
            litDone[i] = litSeq[i];
            lat = cyc - litArmCyc[i] - 1;
            nCompared++;
            if (doutA[i] !== litData[i]) begin
                nMismatched++;
                $display("[TB] FAIL litData inst%0d: got %h, want %h", i, doutA[i], litData[i]);
            end
            nCompared++;
            if (errA[i] !== litErr[i]) begin
                nMismatched++;
                $display("[TB] FAIL litErr inst%0d: got %b, want %b", i, errA[i], litErr[i]);
            end
            nCompared++;
            if (lat != litLat[i]) begin
                nMismatched++;
                $display("[TB] FAIL litLatency inst%0d: got %0d, want %0d", i, lat, litLat[i]);
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        litDone     = '{0, 0};
        forever begin
            @(negedge clk);
            if (checkEn) begin
                for (int i = 0; i < 2; i++) checkOutput(i);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int i, input logic [15:0] d, input bit arm,
                                 input logic [15:0] eD, input logic eE, input int eL);
        if (arm) begin
            litData[i]   = eD;
            litErr[i]    = eE;
            litLat[i]    = eL;
            litArmCyc[i] = cyc;
            litSeq[i]    = litSeq[i] + 1;
        end
        dinA[i] = d;
        riA[i]  = 1'b1;
        @(posedge clk);
        #1;
        riA[i]  = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dinA[i] = 16'h0; riA[i] = 1'b0;
            litSeq[i] = 0; litData[i] = 16'h0; litErr[i] = 1'b0;
            litLat[i] = 0; litArmCyc[i] = 0;
        end
        idle(3);
        reset = 1'b0;
        idle(2);

        applyStimulus(0, 16'h0001, 1, 16'h3C00, 1'b0, 17); idle(22);
        applyStimulus(0, 16'h0801, 1, 16'h6800, 1'b0, 6);  idle(10);
        applyStimulus(0, 16'h0803, 1, 16'h6802, 1'b0, 6);  idle(10);
        applyStimulus(0, 16'hFFEF, 1, 16'h7BFF, 1'b0, 2);  idle(5);
        applyStimulus(0, 16'hFFF0, 1, 16'h7C00, 1'b1, 2);  idle(5);
        applyStimulus(1, 16'h8000, 1, 16'hF800, 1'b0, 2);  idle(5);
        applyStimulus(1, 16'hFFFF, 1, 16'hBC00, 1'b0, 17); idle(22);
        applyStimulus(1, 16'h0000, 1, 16'h0000, 1'b0, 1);  idle(5);

        // Second request while busy must vanish without being queued.
        applyStimulus(0, 16'h0001, 1, 16'h3C00, 1'b0, 17); idle(3);
        applyStimulus(0, 16'h0803, 0, 16'h0, 1'b0, 0);     idle(22);

        // Reset during NORM aborts the conversion and clears the result.
        applyStimulus(0, 16'h0001, 0, 16'h0, 1'b0, 0);     idle(3);
        reset = 1'b1; idle(1); reset = 1'b0; idle(22);

        // Reset wins over a simultaneous request.
        applyStimulus(0, 16'hFFEF, 0, 16'h0, 1'b0, 0);     idle(5);
        reset = 1'b1;
        applyStimulus(0, 16'h0803, 0, 16'h0, 1'b0, 0);
        reset = 1'b0; idle(12);

        // Request issued in the R_O cycle is accepted immediately.
        applyStimulus(0, 16'hFFEF, 1, 16'h7BFF, 1'b0, 2);
        n = 0;
        while (roA[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        applyStimulus(0, 16'h0801, 1, 16'h6800, 1'b0, 6);  idle(12);

        repeat (1500) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                riA[i]  = ($urandom_range(0, 2) == 0);
                dinA[i] = randData();
            end
            idle(1);
        end
        reset = 1'b0;
        riA[0] = 1'b0;
        riA[1] = 1'b0;
        idle(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
